divfreq_prog: RTL and testbench
===============================

// Module: divfreq_prog
// PURPOSE
//  Runtime-programmable clock-enable / square-wave generator; parametrised successor of the fixed 50 MHz dividers.
//  Produces a divided square wave with programmable period and high time, plus a one-cycle tick strobe per period.
//  Period and high-time changes apply glitch-free at the next period boundary.
//  Sits beside the system clock to drive display scanning, debouncers and slow FSM timebases.
// PARAMETERS
//  WIDTH        26       counter/divisor width in bits; holds any divisor up to 2^WIDTH-1
//  DEFAULT_DIV  8333334  reset period in clock50 cycles (6 Hz at 50 MHz); must satisfy 2 <= DEFAULT_DIV < 2^WIDTH
// PORTS
//  clock50    in   1      system clock; all logic on posedge
//  reset_n    in   1      asynchronous, active-low reset
//  en         in   1      run enable; 0 = stopped, outputs low
//  load       in   1      one-cycle request to load div_in/high_in
//  div_in     in   WIDTH  requested period in clock50 cycles
//  high_in    in   WIDTH  requested high time in clock50 cycles
//  clk_out    out  1      divided square wave, registered
//  tick       out  1      one-cycle strobe on first high cycle of each period, registered
//  load_busy  out  1      accepted load pending, waiting for period boundary
//  load_err   out  1      one-cycle strobe: load rejected (div_in < 2)
// BEHAVIOUR
//  Reset (async, reset_n=0): cnt=0, run=0, div_reg=DEFAULT_DIV, hi_reg=DEFAULT_DIV/2 (floor), pending cleared,
//   clk_out=0, tick=0, load_busy=0, load_err=0. Reset mid-period discards pending load and restarts from defaults.
//  High-time clamp on accept: hi = high_in clamped to [1, div_in-1]; output never stuck at a constant level.
//  Load validation: div_in < 2 -> load_err=1 next cycle, request ignored, existing pending value kept.
//  Stopped (run=0): valid load applied to div_reg/hi_reg on the same edge; load_busy stays 0.
//  Running (run=1): valid load captured into pending regs, load_busy=1 next cycle; later load overwrites pending (last wins).
//  Edge with en=1, run=0 (start): run<=1, pending applied, cnt<=0, clk_out<=1, tick<=1.
//  Edge with en=1, run=1, cnt==div_reg-1 (boundary): pending applied if set (load_busy<=0), cnt<=0, clk_out<=1, tick<=1.
//  Edge with en=1, run=1, otherwise: cnt<=cnt+1, clk_out<=(cnt+1 < hi_reg), tick<=0.
//  Load on a boundary edge becomes pending for the NEXT boundary (not the one being taken).
//  Edge with en=0: run<=0, cnt<=0, clk_out<=0, tick<=0; pending load applied immediately, load_busy<=0.
//  Result: period exactly div_reg cycles, clk_out high exactly hi_reg cycles then low div_reg-hi_reg cycles.
//  Latency: en rise -> clk_out/tick high after 1 edge; load while stopped effective on the next period started.
//  Arithmetic: cnt unsigned WIDTH bits; cnt+1 compared at WIDTH+1 bits, never wraps since cnt <= div_reg-1.
//  No combinational path from inputs to outputs; all outputs registered.
// TESTING (bench uses DEFAULT_DIV=10, WIDTH=8)
//  T1 reset then en=1 -> tick every 10 cycles, clk_out 5 high / 5 low, first tick 1 cycle after en rise.
//  T2 running, load div_in=4 high_in=1 mid-period -> load_busy=1 until boundary; old 10-cycle period
//     completes, then period 4 with clk_out 1 high / 3 low.
//  T3 load div_in=1 -> load_err one cycle, load_busy unchanged, period unchanged; load div_in=6 high_in=9 ->
//     high clamped to 5 (5 high / 1 low); high_in=0 -> clamped to 1.
//  T4 two loads before boundary (div 8 then div 3) -> only div 3 applied; load coincident with boundary edge
//     -> applied one full period later.
//  T5 en dropped mid-period -> clk_out/tick 0 next edge, pending applied, load_busy 0; en re-raised ->
//     new period starts from cnt=0 with tick.
//  T6 reset_n asserted mid-period with load pending -> outputs 0 immediately (async), defaults restored, 10-cycle period after en.

Source files
------------

// File: rtl/divfreq_prog.sv
// divfreq_prog: programmable square-wave / tick generator with glitch-free period reload
//   clock50_i   system clock, all state on posedge
//   reset_n_i   asynchronous active-low reset
//   en_i        run enable (0 = stopped, outputs low)
//   load_i      one-cycle request to load div_in_i/high_in_i
//   div_in_i    requested period in clock cycles (must be >= 2)
//   high_in_i   requested high time, clamped to [1, div_in_i-1]
//   clk_out_o   registered divided square wave
//   tick_o      registered one-cycle strobe on the first high cycle of each period
//   load_busy_o accepted load waiting for the next period boundary
//   load_err_o  one-cycle strobe for a rejected load (div_in_i < 2)
module divfreq_prog #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 8333334
) (
  input  logic             clock50_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic [WIDTH-1:0] high_in_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             load_busy_o,
  output logic             load_err_o
);
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HI  = WIDTH'(DEFAULT_DIV / 2);
  logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, hi_q, hi_d, pdiv_q, pdiv_d, phi_q, phi_d, hi_c;
  logic             run_q, run_d, pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, err_q, err_d;
  logic             ld_ok, bnd, idle;
  logic [WIDTH:0]   cnt_inc;
  always_comb begin
    ld_ok   = load_i && (div_in_i >= WIDTH'(2));
    hi_c    = (high_in_i == '0) ? WIDTH'(1) : (high_in_i >= div_in_i) ? div_in_i - WIDTH'(1) : high_in_i;
    bnd     = cnt_q == div_q - WIDTH'(1);
    // one bit wider so the high-time compare can never wrap
    cnt_inc = {1'b0, cnt_q} + (WIDTH+1)'(1);
    // stopping or starting: any pending/new load takes effect right away
    idle    = !en_i || !run_q;
    div_d   = div_q;
    hi_d    = hi_q;
    pdiv_d  = pdiv_q;
    phi_d   = phi_q;
    pend_d  = pend_q;
    if (idle) begin
      if (pend_q) begin
        div_d = pdiv_q;
        hi_d  = phi_q;
      end
      if (ld_ok) begin
        div_d = div_in_i;
        hi_d  = hi_c;
      end
      pend_d = 1'b0;
    end else begin
      if (bnd && pend_q) begin
        div_d = pdiv_q;
        hi_d  = phi_q;
      end
      // a load on the boundary edge stays pending for the following boundary
      if (ld_ok) begin
        pdiv_d = div_in_i;
        phi_d  = hi_c;
      end
      pend_d = ld_ok || (pend_q && !bnd);
    end
    run_d  = en_i;
    cnt_d  = (idle || bnd) ? '0 : cnt_inc[WIDTH-1:0];
    clk_d  = en_i && (idle || bnd || (cnt_inc < {1'b0, hi_q}));
    tick_d = en_i && (idle || bnd);
    err_d  = load_i && !ld_ok;
  end
  always_ff @(posedge clock50_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      hi_q   <= DEF_HI;
      pdiv_q <= DEF_DIV;
      phi_q  <= DEF_HI;
      run_q  <= 1'b0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      pdiv_q <= pdiv_d;
      phi_q  <= phi_d;
      run_q  <= run_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end
  assign clk_out_o   = clk_q;
  assign tick_o      = tick_q;
  assign load_busy_o = pend_q;
  assign load_err_o  = err_q;
endmodule

// File: tb/tb_divfreq_prog.sv
// tb_divfreq_prog: scoreboard bench for divfreq_prog (WIDTH=8, DEFAULT_DIV=10)
module tb_divfreq_prog;
  logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, load = 1'b0;
  logic [7:0] div_in = '0, high_in = '0;
  logic       clk_out, tick, busy, err;
  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;
  exp_t q[$];
  int   n_vec = 0, n_err = 0;
  divfreq_prog #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
    .clock50_i(clk), .reset_n_i(rst_n), .en_i(en), .load_i(load),
    .div_in_i(div_in), .high_in_i(high_in),
    .clk_out_o(clk_out), .tick_o(tick), .load_busy_o(busy), .load_err_o(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {clk_out,tick,busy,err} got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask
  // monitor: outputs are valid every cycle, so pop one expectation per edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {clk_out, tick, busy, err}, e.v);
    end
  end
  task automatic step(input logic e, input logic l, input logic [7:0] d, input logic [7:0] h,
                      input logic [3:0] exp, input string tag);
    exp_t x;
    @(negedge clk);
    en = e;
    load = l;
    div_in = d;
    high_in = h;
    x.v = exp;
    x.tag = tag;
    q.push_back(x);
  endtask
  // cycles from..to of a period of length d with h high cycles, no load issued
  task automatic run(input int d, input int h, input int from, input int to, input logic b, input string tag);
    for (int i = from; i <= to; i++) step(1'b1, 1'b0, 8'd0, 8'd0, {i < h, i == 0, b, 1'b0}, tag);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 check("reset", {clk_out, tick, busy, err}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'b0000, "idle");
    // T1 default period 10, 5 high
    run(10, 5, 0, 9, 1'b0, "t1_p10a");
    run(10, 5, 0, 9, 1'b0, "t1_p10b");
    // T2 mid-period load of div 4 / high 1
    run(10, 5, 0, 2, 1'b0, "t2_pre");
    step(1'b1, 1'b1, 8'd4, 8'd1, 4'b1010, "t2_load");
    run(10, 5, 4, 9, 1'b1, "t2_busy");
    run(4, 1, 0, 3, 1'b0, "t2_p4a");
    run(4, 1, 0, 3, 1'b0, "t2_p4b");
    // T3 rejected load, then high clamp to div-1 and to 1
    run(4, 1, 0, 0, 1'b0, "t3_a");
    step(1'b1, 1'b1, 8'd1, 8'd0, 4'b0001, "t3_err");
    run(4, 1, 2, 3, 1'b0, "t3_b");
    run(4, 1, 0, 0, 1'b0, "t3_c");
    step(1'b1, 1'b1, 8'd6, 8'd9, 4'b0010, "t3_ld6");
    step(1'b1, 1'b1, 8'd0, 8'd3, 4'b0011, "t3_err_busy");
    run(4, 1, 3, 3, 1'b1, "t3_d");
    run(6, 5, 0, 0, 1'b0, "t3_p6a");
    step(1'b1, 1'b1, 8'd5, 8'd0, 4'b1010, "t3_ld5");
    run(6, 5, 2, 5, 1'b1, "t3_p6b");
    run(5, 1, 0, 4, 1'b0, "t3_p5");
    // T4 last load wins; load on boundary waits a full period
    run(5, 1, 0, 0, 1'b0, "t4_a");
    step(1'b1, 1'b1, 8'd8, 8'd4, 4'b0010, "t4_ld8");
    step(1'b1, 1'b1, 8'd3, 8'd1, 4'b0010, "t4_ld3");
    run(5, 1, 3, 4, 1'b1, "t4_b");
    run(3, 1, 0, 2, 1'b0, "t4_p3a");
    step(1'b1, 1'b1, 8'd4, 8'd2, 4'b1110, "t4_ld_bnd");
    run(3, 1, 1, 2, 1'b1, "t4_p3b");
    run(4, 2, 0, 3, 1'b0, "t4_p4");
    // T5 en drop applies pending, restart with tick
    run(4, 2, 0, 1, 1'b0, "t5_a");
    step(1'b1, 1'b1, 8'd7, 8'd3, 4'b0010, "t5_ld7");
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'b0000, "t5_stop");
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'b0000, "t5_stopped");
    run(7, 3, 0, 6, 1'b0, "t5_p7");
    // T6 async reset with load pending
    run(7, 3, 0, 1, 1'b0, "t6_a");
    step(1'b1, 1'b1, 8'd4, 8'd1, 4'b1010, "t6_ld4");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("t6_async_rst", {clk_out, tick, busy, err}, 4'b0000);
    @(negedge clk) begin
      en = 1'b0;
      load = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    run(10, 5, 0, 9, 1'b0, "t6_p10a");
    run(10, 5, 0, 9, 1'b0, "t6_p10b");
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
